// File: rtl/ice_gpio_pkg.sv
// Shared register map and address width for the ice_gpio_bank GPIO block.
package ice_gpio_pkg;

  localparam int GPIO_AW = 3;

  localparam logic [GPIO_AW-1:0] GPIO_OUT       = 3'd0;
  localparam logic [GPIO_AW-1:0] GPIO_OE        = 3'd1;
  localparam logic [GPIO_AW-1:0] GPIO_IN        = 3'd2;
  localparam logic [GPIO_AW-1:0] GPIO_RISE_PEND = 3'd3;
  localparam logic [GPIO_AW-1:0] GPIO_FALL_PEND = 3'd4;
  localparam logic [GPIO_AW-1:0] GPIO_IRQ_EN    = 3'd5;

endpackage

// File: rtl/ice_gpio_debounce.sv
// One GPIO input channel: 2-FF synchroniser followed by an optional debouncer.
// The debouncer is built only when ICE_GPIO_DEBOUNCE_EN is defined.
module ice_gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 1200,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic db
);

  if (DEBOUNCE_CYCLES < 1 || CNT_W < $clog2(DEBOUNCE_CYCLES + 1)) begin : g_bad_cfg
    $error("ice_gpio_debounce: DEBOUNCE_CYCLES must be >= 1 and CNT_W wide enough");
  end

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], pin_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

`ifdef ICE_GPIO_DEBOUNCE_EN
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d = sync_q[1];
      else                                      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;
`else
  assign db = sync_q[1];
`endif

endmodule

// File: rtl/ice_gpio_bank.sv
// N-channel GPIO bank: OUT/OE registers, synchronised inputs, sticky edge pending bits and irq.
// Define ICE_GPIO_DEBOUNCE_EN to insert the per-channel debounce filter.
module ice_gpio_bank
  import ice_gpio_pkg::*;
#(
  parameter int N_PINS          = 24,
  parameter int DEBOUNCE_CYCLES = 1200,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PINS-1:0]  pin_i,
  output logic [N_PINS-1:0]  pin_o,
  output logic [N_PINS-1:0]  pin_oe,
  input  logic               wr_en,
  input  logic [GPIO_AW-1:0] wr_addr,
  input  logic [N_PINS-1:0]  wr_data,
  input  logic               rd_en,
  input  logic [GPIO_AW-1:0] rd_addr,
  output logic [N_PINS-1:0]  rd_data,
  output logic               rd_valid,
  output logic               irq
);

  logic [N_PINS-1:0] db;

  for (genvar i = 0; i < N_PINS; i++) begin : g_ch
    ice_gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .pin_i(pin_i[i]),
      .db   (db[i])
    );
  end

  logic [N_PINS-1:0] out_q, out_d, oe_q, oe_d, irq_en_q, irq_en_d;
  logic [N_PINS-1:0] rise_q, rise_d, fall_q, fall_d, db_prev_q, db_prev_d;
  logic [N_PINS-1:0] rise_clr, fall_clr, rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d, irq_q, irq_d;

  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    irq_en_d = irq_en_q;
    rise_clr = '0;
    fall_clr = '0;
    if (wr_en) begin
      case (wr_addr)
        GPIO_OUT:       out_d    = wr_data;
        GPIO_OE:        oe_d     = wr_data;
        GPIO_RISE_PEND: rise_clr = wr_data;
        GPIO_FALL_PEND: fall_clr = wr_data;
        GPIO_IRQ_EN:    irq_en_d = wr_data;
        default: ;
      endcase
    end
    // New edge events are OR-ed in after the clear so a same-cycle event wins.
    db_prev_d = db;
    rise_d    = (rise_q & ~rise_clr) | (db & ~db_prev_q);
    fall_d    = (fall_q & ~fall_clr) | (~db & db_prev_q);
    irq_d     = |((rise_q | fall_q) & irq_en_q);
  end

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = '0;
    if (rd_en) begin
      case (rd_addr)
        GPIO_OUT:       rd_data_d = out_q;
        GPIO_OE:        rd_data_d = oe_q;
        GPIO_IN:        rd_data_d = db;
        GPIO_RISE_PEND: rd_data_d = rise_q;
        GPIO_FALL_PEND: rd_data_d = fall_q;
        GPIO_IRQ_EN:    rd_data_d = irq_en_q;
        default:        rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      oe_q       <= '0;
      irq_en_q   <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      db_prev_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      irq_en_q   <= irq_en_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      db_prev_q  <= db_prev_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign pin_o    = out_q;
  assign pin_oe   = oe_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule
